// File: rtl/mdr_load_align.sv
// mdr_load_align: memory data register with lane alignment.
// Loads: captures the addressed byte/half/word/double lane of the memory read
// data under a request/valid handshake and sign- or zero-extends it.
// Stores: drives lane-shifted write data and byte enables until acknowledged.
// A watchdog aborts any access that sees no mem_rvalid within TIMEOUT cycles.
module mdr_load_align #(
  parameter int DATA_W  = 32,
  parameter int ALW     = $clog2(DATA_W / 8),
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_start,
  input  logic                  wr_start,
  input  logic [ALW-1:0]        addr_lo,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic                  busy,
  output logic [DATA_W-1:0]     mdr_result,
  output logic                  mdr_valid,
  output logic                  err
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ALW-1:0]    addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic              load_q, load_d;

  logic              mem_req_d, mem_we_d, busy_d, mdr_valid_d, err_d;
  logic [DATA_W-1:0] mem_wdata_d, mdr_result_d;
  logic [BE_W-1:0]   mem_be_d;

  logic [DATA_W-1:0] lane, kept, extended;
  logic              lane_msb;
  logic [DATA_W-1:0] store_data;
  logic [BE_W-1:0]   store_be;

  // Bit mask covering the low bytes touched by an access of the given size.
  function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] s);
    case (s)
      2'b00:   size_mask = DATA_W'(8'hFF);
      2'b01:   size_mask = DATA_W'(16'hFFFF);
      2'b10:   size_mask = DATA_W'(32'hFFFF_FFFF);
      default: size_mask = '1;
    endcase
  endfunction

  // Unshifted byte-enable pattern for an access of the given size.
  function automatic logic [BE_W-1:0] be_mask(input logic [1:0] s);
    case (s)
      2'b00:   be_mask = BE_W'(1'b1);
      2'b01:   be_mask = BE_W'(2'b11);
      2'b10:   be_mask = BE_W'(4'hF);
      default: be_mask = '1;
    endcase
  endfunction

  // Natural alignment check; doubleword only exists on a 64-bit port.
  function automatic logic access_legal(input logic [ALW-1:0] a, input logic [1:0] s);
    case (s)
      2'b00:   access_legal = 1'b1;
      2'b01:   access_legal = (a[0] == 1'b0);
      2'b10:   access_legal = (a[1:0] == 2'b00);
      default: access_legal = (DATA_W == 64) && (a == '0);
    endcase
  endfunction

  // Load lane extraction and extension from the latched address/size/sign.
  always_comb begin
    lane = mem_rdata >> {addr_q, 3'b000};
    kept = lane & size_mask(size_q);
    case (size_q)
      2'b00:   lane_msb = lane[7];
      2'b01:   lane_msb = lane[15];
      2'b10:   lane_msb = lane[31];
      default: lane_msb = lane[DATA_W-1];
    endcase
    extended = (sign_q && lane_msb) ? (kept | ~size_mask(size_q)) : kept;
  end

  // Store data and byte enables placed on the addressed lane.
  always_comb begin
    store_data = (wr_data & size_mask(size)) << {addr_lo, 3'b000};
    store_be   = be_mask(size) << addr_lo;
  end

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    size_d       = size_q;
    sign_d       = sign_q;
    load_d       = load_q;
    mem_req_d    = mem_req;
    mem_we_d     = mem_we;
    mem_wdata_d  = mem_wdata;
    mem_be_d     = mem_be;
    busy_d       = busy;
    mdr_result_d = mdr_result;
    mdr_valid_d  = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (rd_start || wr_start) begin
          if (!access_legal(addr_lo, size)) begin
            err_d = 1'b1;
          end else begin
            state_d   = WAIT;
            cnt_d     = 8'd0;
            addr_d    = addr_lo;
            size_d    = size;
            sign_d    = sign_ext;
            load_d    = rd_start;
            mem_req_d = 1'b1;
            busy_d    = 1'b1;
            mem_we_d  = !rd_start;
            mem_be_d  = rd_start ? '0 : store_be;
            if (!rd_start) begin
              mem_wdata_d = store_data;
            end
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          if (load_q) begin
            mdr_result_d = extended;
            mdr_valid_d  = 1'b1;
          end
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = '0;
          busy_d    = 1'b0;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          err_d     = 1'b1;
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = '0;
          busy_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      addr_q     <= '0;
      size_q     <= 2'b00;
      sign_q     <= 1'b0;
      load_q     <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      busy       <= 1'b0;
      mdr_result <= '0;
      mdr_valid  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      load_q     <= load_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_wdata  <= mem_wdata_d;
      mem_be     <= mem_be_d;
      busy       <= busy_d;
      mdr_result <= mdr_result_d;
      mdr_valid  <= mdr_valid_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_mdr_load_align.sv
// Testbench for mdr_load_align: a 32-bit and a 64-bit instance share one
// stimulus stream; a transaction-level reference model predicts both.
module tb_mdr_load_align;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, rd_start, wr_start, sign_ext, mem_rvalid;
  logic [2:0]  addr_lo;
  logic [1:0]  size;
  logic [63:0] wr_data, mem_rdata;

  logic        req32, we32, busy32, valid32, err32;
  logic [31:0] wd32, res32;
  logic [3:0]  be32;
  logic        req64, we64, busy64, valid64, err64;
  logic [63:0] wd64, res64;
  logic [7:0]  be64;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mdr_load_align #(.DATA_W(32), .TIMEOUT(TO)) dut32 (
    .clk(clk), .rst(rst), .rd_start(rd_start), .wr_start(wr_start),
    .addr_lo(addr_lo[1:0]), .size(size), .sign_ext(sign_ext),
    .wr_data(wr_data[31:0]), .mem_rdata(mem_rdata[31:0]), .mem_rvalid(mem_rvalid),
    .mem_req(req32), .mem_we(we32), .mem_wdata(wd32), .mem_be(be32),
    .busy(busy32), .mdr_result(res32), .mdr_valid(valid32), .err(err32));

  mdr_load_align #(.DATA_W(64), .TIMEOUT(TO)) dut64 (
    .clk(clk), .rst(rst), .rd_start(rd_start), .wr_start(wr_start),
    .addr_lo(addr_lo), .size(size), .sign_ext(sign_ext),
    .wr_data(wr_data), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_req(req64), .mem_we(we64), .mem_wdata(wd64), .mem_be(be64),
    .busy(busy64), .mdr_result(res64), .mdr_valid(valid64), .err(err64));

  // Reference model: one outstanding access per instance, index 0 = 32-bit.
  bit          m_open[2], m_load[2], m_sign[2];
  int          m_addr[2], m_bytes[2], m_waited[2];
  logic [63:0] e_res[2], e_wdata[2];
  logic [7:0]  e_be[2];
  bit          e_req[2], e_we[2], e_busy[2], e_valid[2], e_err[2];

  typedef struct {
    string       name;
    bit          rd, wr;
    logic [2:0]  addr;
    logic [1:0]  size;
    bit          sign;
    logic [63:0] wdata, rdata;
    bit          err32;
    logic [31:0] res32, wd32;
    logic [3:0]  be32;
    bit          err64;
    logic [63:0] res64, wd64;
    logic [7:0]  be64;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [63:0] load_value(int dw, int a, int bytes, bit sgn, logic [63:0] rdata);
    logic [127:0] v;
    v = {64'd0, rdata} >> (8 * a);
    v = v % (128'd1 << (8 * bytes));
    if (sgn && v >= (128'd1 << (8 * bytes - 1)))
      v = v + (128'd1 << dw) - (128'd1 << (8 * bytes));
    v = v % (128'd1 << dw);
    return v[63:0];
  endfunction

  function automatic logic [63:0] store_value(int dw, int a, int bytes, logic [63:0] wdata);
    logic [127:0] v;
    v = ({64'd0, wdata} % (128'd1 << (8 * bytes))) << (8 * a);
    v = v % (128'd1 << dw);
    return v[63:0];
  endfunction

  task automatic close_access(int i);
    m_open[i] = 0;
    e_req[i]  = 0;
    e_we[i]   = 0;
    e_be[i]   = 8'd0;
    e_busy[i] = 0;
  endtask

  task automatic model_edge(int i);
    int dw, a, bytes;
    logic [63:0] rdat;
    dw    = (i == 0) ? 32 : 64;
    a     = (i == 0) ? int'(addr_lo[1:0]) : int'(addr_lo);
    bytes = 1 << size;
    rdat  = (i == 0) ? {32'd0, mem_rdata[31:0]} : mem_rdata;
    e_valid[i] = 0;
    e_err[i]   = 0;
    if (rst) begin
      close_access(i);
      e_res[i]   = 64'd0;
      e_wdata[i] = 64'd0;
    end else if (!m_open[i]) begin
      if (rd_start || wr_start) begin
        if (8 * bytes > dw || (a % bytes) != 0) begin
          e_err[i] = 1;
        end else begin
          m_open[i]   = 1;
          m_load[i]   = rd_start;
          m_addr[i]   = a;
          m_bytes[i]  = bytes;
          m_sign[i]   = sign_ext;
          m_waited[i] = 0;
          e_req[i]    = 1;
          e_busy[i]   = 1;
          e_we[i]     = !rd_start;
          if (!rd_start) begin
            e_wdata[i] = store_value(dw, a, bytes, wr_data);
            e_be[i]    = 8'(((1 << bytes) - 1) << a);
          end
        end
      end
    end else begin
      if (mem_rvalid) begin
        if (m_load[i]) begin
          e_res[i]   = load_value(dw, m_addr[i], m_bytes[i], m_sign[i], rdat);
          e_valid[i] = 1;
        end
        close_access(i);
      end else if (m_waited[i] == TO - 1) begin
        e_err[i] = 1;
        close_access(i);
      end else begin
        m_waited[i]++;
      end
    end
  endtask

  task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic check_dut(int i, string tag, logic req, logic we, logic bsy, logic vld,
                           logic er, logic [63:0] res, logic [63:0] wd, logic [7:0] be);
    checkOutput({tag, "_req"},   {63'd0, req}, {63'd0, e_req[i]});
    checkOutput({tag, "_we"},    {63'd0, we},  {63'd0, e_we[i]});
    checkOutput({tag, "_busy"},  {63'd0, bsy}, {63'd0, e_busy[i]});
    checkOutput({tag, "_valid"}, {63'd0, vld}, {63'd0, e_valid[i]});
    checkOutput({tag, "_err"},   {63'd0, er},  {63'd0, e_err[i]});
    checkOutput({tag, "_res"},   res, e_res[i]);
    checkOutput({tag, "_wdata"}, wd, e_wdata[i]);
    checkOutput({tag, "_be"},    {56'd0, be}, {56'd0, e_be[i]});
  endtask

  // One clock: advance the model on the edge, compare just after it.
  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_dut(0, "m32", req32, we32, busy32, valid32, err32, {32'd0, res32}, {32'd0, wd32}, {4'd0, be32});
    check_dut(1, "m64", req64, we64, busy64, valid64, err64, res64, wd64, be64);
  endtask

  task automatic set_req(bit rd, bit wr, logic [2:0] a, logic [1:0] s, bit sg);
    rd_start = rd; wr_start = wr; addr_lo = a; size = s; sign_ext = sg;
  endtask

  task automatic applyStimulus(vec_t v);
    set_req(v.rd, v.wr, v.addr, v.size, v.sign);
    wr_data = v.wdata; mem_rdata = v.rdata; mem_rvalid = 0;
    tick();
    checkOutput({v.name, "_err32"}, {63'd0, err32}, {63'd0, v.err32});
    checkOutput({v.name, "_err64"}, {63'd0, err64}, {63'd0, v.err64});
    checkOutput({v.name, "_req32"}, {63'd0, req32}, {63'd0, !v.err32});
    checkOutput({v.name, "_req64"}, {63'd0, req64}, {63'd0, !v.err64});
    if (v.wr && !v.rd) begin
      if (!v.err32) begin
        checkOutput({v.name, "_wd32"}, {32'd0, wd32}, {32'd0, v.wd32});
        checkOutput({v.name, "_be32"}, {60'd0, be32}, {60'd0, v.be32});
      end
      if (!v.err64) begin
        checkOutput({v.name, "_wd64"}, wd64, v.wd64);
        checkOutput({v.name, "_be64"}, {56'd0, be64}, {56'd0, v.be64});
      end
    end
    set_req(0, 0, v.addr, v.size, v.sign);
    mem_rvalid = 1;
    tick();
    checkOutput({v.name, "_res32"}, {32'd0, res32}, {32'd0, v.res32});
    checkOutput({v.name, "_res64"}, res64, v.res64);
    checkOutput({v.name, "_vld32"}, {63'd0, valid32}, {63'd0, v.rd && !v.err32});
    checkOutput({v.name, "_vld64"}, {63'd0, valid64}, {63'd0, v.rd && !v.err64});
    mem_rvalid = 0;
    tick();
  endtask

  initial begin
    int req_cycles;
    bit saw_err;

    vecs[0]  = '{"ld_b3_sx", 1, 0, 3'd3, 2'd0, 1, 64'd0, 64'h0000_0000_8012_3456,
                 0, 32'hFFFF_FF80, 32'd0, 4'd0, 0, 64'hFFFF_FFFF_FFFF_FF80, 64'd0, 8'd0};
    vecs[1]  = '{"ld_b3_zx", 1, 0, 3'd3, 2'd0, 0, 64'd0, 64'h0000_0000_8012_3456,
                 0, 32'h0000_0080, 32'd0, 4'd0, 0, 64'h80, 64'd0, 8'd0};
    vecs[2]  = '{"ld_h2", 1, 0, 3'd2, 2'd1, 0, 64'd0, 64'h0000_0000_BEEF_1234,
                 0, 32'h0000_BEEF, 32'd0, 4'd0, 0, 64'hBEEF, 64'd0, 8'd0};
    vecs[3]  = '{"ld_h1_mis", 1, 0, 3'd1, 2'd1, 0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF,
                 1, 32'h0000_BEEF, 32'd0, 4'd0, 1, 64'hBEEF, 64'd0, 8'd0};
    vecs[4]  = '{"st_b2", 0, 1, 3'd2, 2'd0, 0, 64'h1234_56AB, 64'h1234,
                 0, 32'h0000_BEEF, 32'h00AB_0000, 4'b0100, 0, 64'hBEEF, 64'h00AB_0000, 8'b0000_0100};
    vecs[5]  = '{"ld_d0", 1, 0, 3'd0, 2'd3, 0, 64'd0, 64'h8000_0000_0000_0001,
                 1, 32'h0000_BEEF, 32'd0, 4'd0, 0, 64'h8000_0000_0000_0001, 64'd0, 8'd0};
    vecs[6]  = '{"ld_w4_sx", 1, 0, 3'd4, 2'd2, 1, 64'd0, 64'h8000_0000_1234_5678,
                 0, 32'h1234_5678, 32'd0, 4'd0, 0, 64'hFFFF_FFFF_8000_0000, 64'd0, 8'd0};
    vecs[7]  = '{"st_h6", 0, 1, 3'd6, 2'd1, 0, 64'h1111_2222_3333_CDEF, 64'd0,
                 0, 32'h1234_5678, 32'hCDEF_0000, 4'b1100, 0, 64'hFFFF_FFFF_8000_0000,
                 64'hCDEF_0000_0000_0000, 8'b1100_0000};
    vecs[8]  = '{"st_w2_mis", 0, 1, 3'd2, 2'd2, 0, 64'h5555_5555, 64'd0,
                 1, 32'h1234_5678, 32'd0, 4'd0, 1, 64'hFFFF_FFFF_8000_0000, 64'd0, 8'd0};
    vecs[9]  = '{"ld_w0_zx", 1, 0, 3'd0, 2'd2, 0, 64'd0, 64'hAAAA_AAAA_F000_0000,
                 0, 32'hF000_0000, 32'd0, 4'd0, 0, 64'h0000_0000_F000_0000, 64'd0, 8'd0};
    vecs[10] = '{"st_d0", 0, 1, 3'd0, 2'd3, 0, 64'h0123_4567_89AB_CDEF, 64'd0,
                 1, 32'hF000_0000, 32'd0, 4'd0, 0, 64'h0000_0000_F000_0000,
                 64'h0123_4567_89AB_CDEF, 8'hFF};
    vecs[11] = '{"rdwr_b5", 1, 1, 3'd5, 2'd0, 1, 64'hFFFF, 64'h0000_7F00_0000_0000,
                 0, 32'd0, 32'd0, 4'd0, 0, 64'h7F, 64'd0, 8'd0};
    vecs[12] = '{"ld_h6_sx", 1, 0, 3'd6, 2'd1, 1, 64'd0, 64'h8001_0000_0000_0000,
                 0, 32'd0, 32'd0, 4'd0, 0, 64'hFFFF_FFFF_FFFF_8001, 64'd0, 8'd0};

    rst = 1; set_req(0, 0, 3'd0, 2'd0, 0);
    wr_data = 64'd0; mem_rdata = 64'd0; mem_rvalid = 0;
    tick();
    tick();
    checkOutput("rst_res32", {32'd0, res32}, 64'd0);
    checkOutput("rst_busy64", {63'd0, busy64}, 64'd0);
    rst = 0;
    tick();

    $display("[TB] table-driven vectors");
    for (int k = 0; k < 13; k++) applyStimulus(vecs[k]);

    $display("[TB] reset during WAIT with mem_rvalid");
    set_req(1, 0, 3'd0, 2'd0, 0);
    tick();
    set_req(0, 0, 3'd0, 2'd0, 0);
    rst = 1; mem_rvalid = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    checkOutput("rstw_res32", {32'd0, res32}, 64'd0);
    checkOutput("rstw_res64", res64, 64'd0);
    checkOutput("rstw_valid32", {63'd0, valid32}, 64'd0);
    checkOutput("rstw_req64", {63'd0, req64}, 64'd0);
    rst = 0; mem_rvalid = 0;
    tick();
    set_req(1, 0, 3'd0, 2'd2, 0); mem_rdata = 64'h0000_000C_0000_000B;
    tick();
    set_req(0, 0, 3'd0, 2'd2, 0); mem_rvalid = 1;
    tick();
    checkOutput("after_rst_vld32", {63'd0, valid32}, 64'd1);
    checkOutput("after_rst_res32", {32'd0, res32}, 64'hB);
    checkOutput("after_rst_res64", res64, 64'hB);
    mem_rvalid = 0;
    tick();

    $display("[TB] timeout without mem_rvalid");
    set_req(1, 0, 3'd0, 2'd0, 1);
    tick();
    set_req(0, 0, 3'd0, 2'd0, 1);
    req_cycles = req32 ? 1 : 0;
    saw_err = 0;
    for (int k = 0; k < 10 && !saw_err; k++) begin
      tick();
      if (err32) saw_err = 1;
      else if (req32) req_cycles++;
    end
    checkOutput("to_req_cycles", 64'(req_cycles), 64'd4);
    checkOutput("to_err_seen", {63'd0, saw_err}, 64'd1);
    checkOutput("to_res32", {32'd0, res32}, 64'hB);
    tick();

    $display("[TB] mem_rvalid on terminal WAIT cycle");
    set_req(1, 0, 3'd0, 2'd0, 0);
    tick();
    set_req(0, 0, 3'd0, 2'd0, 0);
    for (int k = 0; k < 3; k++) tick();
    mem_rvalid = 1; mem_rdata = 64'h5A;
    tick();
    checkOutput("term_vld32", {63'd0, valid32}, 64'd1);
    checkOutput("term_err32", {63'd0, err32}, 64'd0);
    checkOutput("term_res32", {32'd0, res32}, 64'h5A);
    mem_rvalid = 0;
    tick();
    checkOutput("term_late_err64", {63'd0, err64}, 64'd0);

    $display("[TB] start while busy, rvalid while idle");
    set_req(1, 0, 3'd0, 2'd0, 0);
    tick();
    set_req(0, 1, 3'd1, 2'd1, 0); wr_data = 64'hFFFF;
    tick();
    checkOutput("busy_we32", {63'd0, we32}, 64'd0);
    set_req(0, 0, 3'd0, 2'd0, 0); mem_rvalid = 1; mem_rdata = 64'h33;
    tick();
    checkOutput("busy_res64", res64, 64'h33);
    tick();
    checkOutput("idle_rv_valid32", {63'd0, valid32}, 64'd0);
    mem_rvalid = 0;
    tick();

    $display("[TB] randomized stimulus");
    for (int k = 0; k < 600; k++) begin
      rst        = ($urandom_range(0, 49) == 0);
      rd_start   = ($urandom_range(0, 3) == 0);
      wr_start   = ($urandom_range(0, 3) == 0);
      addr_lo    = 3'($urandom_range(0, 7));
      size       = 2'($urandom_range(0, 3));
      sign_ext   = 1'($urandom_range(0, 1));
      wr_data    = {$urandom, $urandom};
      mem_rdata  = {$urandom, $urandom};
      mem_rvalid = ($urandom_range(0, 2) == 0);
      tick();
    end
    rst = 0; set_req(0, 0, 3'd0, 2'd0, 0); mem_rvalid = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
